// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Types and constants shared by the CPU datapath blocks.
//   REG_W       architectural register width
//   REG_ADDR_W  register index width
//   ZERO_REG    index of the hard-wired zero register
//   wb_entry_t  one pending write-back (destination index + value)
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int          REG_W      = 32;
    localparam int          REG_ADDR_W = 5;
    localparam int unsigned ZERO_REG   = 0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_W-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_array.sv
// ---------------------------------------------------------------------------
// regfile_array
// 2**ADDR_W x DATA_W register storage. One synchronous write port and two
// asynchronous read ports. Writes to the zero register are dropped, so that
// entry keeps its reset value of 0 forever.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset, clears every entry
//   i_we      write enable
//   i_waddr   write index
//   i_wdata   write value
//   i_raddr1  read port 1 index
//   o_rdata1  read port 1 value (combinational)
//   i_raddr2  read port 2 index
//   o_rdata2  read port 2 value (combinational)
// ---------------------------------------------------------------------------
module regfile_array
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata2
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != ADDR_W'(ZERO_REG))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
// Register file with a buffered write-back port. Write-back results are
// accepted into a small in-order queue and drained into the array one entry
// per cycle. Both read ports bypass from the queue so that decode-stage reads
// always see the newest value, whether it is still queued or already
// committed.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   wr_valid  write-back request valid
//   wr_ready  queue can accept (not full); depends on registered state only
//   wr_addr   destination register
//   wr_data   value to write
//   rd_addr1  read port 1 index
//   rd_data1  read port 1 data (combinational)
//   rd_addr2  read port 2 index
//   rd_data2  read port 2 data (combinational)
//   pending   number of queued, uncommitted writes
//   idle      queue empty
// ---------------------------------------------------------------------------
module regfile_wb_queue
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        rd_addr1,
    output logic [DATA_W-1:0]        rd_data1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic [DATA_W-1:0]        rd_data2,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     idle
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Queue storage; pointers carry an extra wrap bit to tell full from empty.
    logic [ADDR_W-1:0] r_q_addr [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_pending;
    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_tail_idx;
    logic [IDX_W-1:0]  w_idx;

    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_arr_data [2];
    logic [DATA_W-1:0] w_rd_data [2];

    assign w_head_idx = r_rd_ptr[IDX_W-1:0];
    assign w_tail_idx = r_wr_ptr[IDX_W-1:0];

    assign w_full  = (w_tail_idx == w_head_idx) && (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // A write to r0 completes the handshake but never occupies a queue slot.
    assign w_accept = wr_valid && !w_full;
    assign w_push   = w_accept && (wr_addr != ADDR_W'(ZERO_REG));
    assign w_pop    = !w_empty;

    assign w_pending = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Entry payload needs no reset: a slot is only ever read while the
    // pointers mark it as occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[w_tail_idx] <= wr_addr;
            r_q_data[w_tail_idx] <= wr_data;
        end
    end

    regfile_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_pop),
        .i_waddr  (r_q_addr[w_head_idx]),
        .i_wdata  (r_q_data[w_head_idx]),
        .i_raddr1 (rd_addr1),
        .o_rdata1 (w_arr_data[0]),
        .i_raddr2 (rd_addr2),
        .o_rdata2 (w_arr_data[1])
    );

    assign w_rd_addr[0] = rd_addr1;
    assign w_rd_addr[1] = rd_addr2;

    // Walk occupied slots oldest to youngest so a younger match overrides an
    // older one. The head being drained this cycle is still occupied here,
    // which keeps the read coherent across the commit edge. The entry being
    // accepted this cycle is not yet in the queue and is therefore not seen.
    always_comb begin
        w_idx = '0;
        for (int p = 0; p < 2; p++) begin
            w_rd_data[p] = w_arr_data[p];
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = w_head_idx + IDX_W'(k);
                if ((PTR_W'(k) < w_pending) && (r_q_addr[w_idx] == w_rd_addr[p])) begin
                    w_rd_data[p] = r_q_data[w_idx];
                end
            end
            if (w_rd_addr[p] == ADDR_W'(ZERO_REG)) begin
                w_rd_data[p] = '0;
            end
        end
    end

    assign rd_data1 = w_rd_data[0];
    assign rd_data2 = w_rd_data[1];
    assign wr_ready = !w_full;
    assign pending  = w_pending;
    assign idle     = w_empty;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_queue
// Self-checking bench for regfile_wb_queue. A behavioural model (a queue of
// pending writes plus a plain register array) predicts every output each
// cycle; directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_regfile_wb_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data2;
    logic [2:0]  pending;
    logic        idle;

    int n_checks = 0;
    int n_errors = 0;

    wb_entry_t   m_q[$];
    logic [31:0] m_arr [32];
    bit          m_frozen;

    regfile_wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .pending  (pending),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].addr == a) return m_q[i].data;
        end
        return m_arr[a];
    endfunction

    task automatic m_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_arr[i] = 32'd0;
    endtask

    task automatic set_freeze(input bit on);
        if (on) force dut.w_pop = 1'b0;
        else    release dut.w_pop;
        m_frozen = on;
    endtask

    task automatic check_outputs();
        check("wr_ready", {31'd0, wr_ready}, {31'd0, (m_q.size() < DEPTH)});
        check("pending",  {29'd0, pending},  m_q.size());
        check("idle",     {31'd0, idle},     {31'd0, (m_q.size() == 0)});
        check("rd_data1", rd_data1, m_read(rd_addr1));
        check("rd_data2", rd_data2, m_read(rd_addr2));
    endtask

    // Called just after a falling edge with inputs already driven: check,
    // take the rising edge, advance the model with the same inputs.
    task automatic cycle(output bit accepted);
        wb_entry_t e;
        #1 check_outputs();
        @(posedge clk);
        accepted = wr_valid && (m_q.size() < DEPTH);
        if (!m_frozen && m_q.size() > 0) begin
            e = m_q.pop_front();
            m_arr[e.addr] = e.data;
        end
        if (accepted && wr_addr != 5'd0) begin
            e.addr = wr_addr;
            e.data = wr_data;
            m_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive_write(input bit v, input logic [4:0] a, input logic [31:0] d);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic drain(input int n);
        bit acc;
        drive_write(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    initial begin
        bit acc;
        int n_acc;
        int idx;

        rst = 1'b0;
        m_frozen = 1'b0;
        drive_write(1'b0, 5'd0, 32'd0);
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        m_reset();

        // Reset asserted mid-cycle; every address must read 0 while held.
        #3 rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            #1;
            check("rst_rd1", rd_data1, 32'd0);
            check("rst_rd2", rd_data2, 32'd0);
        end
        check("rst_pending", {29'd0, pending}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_ready", {31'd0, wr_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single write, visible through the bypass then from the array.
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd5;
        drive_write(1'b1, 5'd5, 32'hDEADBEEF);
        #1 check("wr5_no_same_cycle_bypass", rd_data1, 32'd0);
        cycle(acc);
        drive_write(1'b0, 5'd0, 32'd0);
        #1 check("wr5_bypass", rd_data1, 32'hDEADBEEF);
        check("wr5_pending", {29'd0, pending}, 32'd1);
        cycle(acc);
        #1 check("wr5_commit", rd_data1, 32'hDEADBEEF);
        check("wr5_idle", {31'd0, idle}, 32'd1);
        cycle(acc);

        // Back-to-back writes while draining keeps pace.
        for (int i = 1; i <= 6; i++) begin
            drive_write(1'b1, 5'(i), 32'(i * 17));
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(i - 1);
            #1 check("fill_ready", {31'd0, wr_ready}, 32'd1);
            cycle(acc);
        end
        drain(3);

        // Drain frozen: the queue fills and back-pressures after DEPTH accepts.
        set_freeze(1'b1);
        n_acc = 0;
        idx = 1;
        for (int c = 0; c < 8; c++) begin
            drive_write(1'b1, 5'(idx), 32'(idx * 17));
            rd_addr1 = 5'(idx);
            cycle(acc);
            if (acc) begin
                n_acc++;
                idx++;
            end
        end
        check("full_accepts", n_acc, 32'd4);
        #1 check("full_ready", {31'd0, wr_ready}, 32'd0);
        check("full_pending", {29'd0, pending}, 32'd4);
        set_freeze(1'b0);
        drain(6);

        // Duplicate destinations: youngest wins, array ends with the last.
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd7;
        set_freeze(1'b1);
        for (int i = 1; i <= 3; i++) begin
            drive_write(1'b1, 5'd7, 32'(i));
            cycle(acc);
        end
        drive_write(1'b0, 5'd0, 32'd0);
        #1 check("dup_bypass", rd_data2, 32'd3);
        set_freeze(1'b0);
        drain(4);
        #1 check("dup_array", rd_data2, 32'd3);
        check("dup_idle", {31'd0, idle}, 32'd1);

        // Zero register write completes the handshake but never queues.
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        drive_write(1'b1, 5'd0, 32'hFFFFFFFF);
        #1 check("r0_ready", {31'd0, wr_ready}, 32'd1);
        cycle(acc);
        check("r0_accepted", {31'd0, acc}, 32'd1);
        drive_write(1'b0, 5'd0, 32'd0);
        #1 check("r0_pending", {29'd0, pending}, 32'd0);
        check("r0_read", rd_data1, 32'd0);
        cycle(acc);

        // Reset mid-operation discards queued writes.
        set_freeze(1'b1);
        for (int i = 8; i <= 10; i++) begin
            drive_write(1'b1, 5'(i), 32'hA000_0000 + 32'(i));
            cycle(acc);
        end
        drive_write(1'b0, 5'd0, 32'd0);
        #2 rst = 1'b1;
        set_freeze(1'b0);
        m_reset();
        for (int i = 8; i <= 10; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(i);
            #1 check("midrst_rd1", rd_data1, 32'd0);
            check("midrst_rd2", rd_data2, 32'd0);
        end
        check("midrst_pending", {29'd0, pending}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with occasional frozen drain.
        for (int c = 0; c < 600; c++) begin
            if (c % 40 == 0) set_freeze($urandom_range(0, 2) == 0);
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_addr  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rd_addr1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rd_addr2 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            cycle(acc);
        end
        set_freeze(1'b0);
        drain(6);
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(a);
            #1 check("final_rd1", rd_data1, m_arr[a]);
            check("final_rd2", rd_data2, m_read(5'(a)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
